// File: rtl/button_conditioner_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_pkg
// Description : Shared state encoding and default timing constants for the
//               push-button conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
package button_conditioner_pkg;

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } btn_state_t;

    // 5 ms debounce and 1 s long-press at a 50 MHz board clock
    localparam int c_default_debounce_cycles   = 250000;
    localparam int c_default_long_press_cycles = 50000000;
    localparam int c_default_cnt_w             = 26;

endpackage : button_conditioner_pkg
`default_nettype wire

// File: rtl/button_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner_if
// Description : Raw button inputs and conditioned outputs for both channels.
// Revision    : 1.0 - initial release
// ============================================================================
interface button_conditioner_if;

    logic jump_n;
    logic crouch_n;
    logic jump_db_n;
    logic crouch_db_n;
    logic jump_press;
    logic jump_release;
    logic crouch_press;
    logic crouch_release;
    logic jump_long;
    logic crouch_long;

    // master drives the raw buttons, slave is the conditioner
    modport master (
        output jump_n, crouch_n,
        input  jump_db_n, crouch_db_n, jump_press, jump_release,
               crouch_press, crouch_release, jump_long, crouch_long
    );

    modport slave (
        input  jump_n, crouch_n,
        output jump_db_n, crouch_db_n, jump_press, jump_release,
               crouch_press, crouch_release, jump_long, crouch_long
    );

endinterface : button_conditioner_if
`default_nettype wire

// File: rtl/button_conditioner_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : debounce_channel
// Description : One button: 2-flop synchroniser, debounce FSM, hold counter,
//               registered level / press / release / long outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module debounce_channel
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = c_default_debounce_cycles,
    parameter int LONG_PRESS_CYCLES = c_default_long_press_cycles,
    parameter int CNT_W             = c_default_cnt_w
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_raw_n,
    output logic      o_db_n,
    output logic      o_press,
    output logic      o_release,
    output logic      o_long
);

    localparam logic [CNT_W-1:0] c_deb  = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] c_long = CNT_W'(LONG_PRESS_CYCLES);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    logic             r_sync1, r_sync2;
    btn_state_t       r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [CNT_W-1:0] r_hold,  w_hold;
    logic             r_db_n,  w_db_n;
    logic             r_press, w_press;
    logic             r_release, w_release;
    logic             r_long,  w_long;
    logic [CNT_W-1:0] w_hold_inc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= ST_RELEASED;
            r_cnt     <= '0;
            r_hold    <= '0;
            r_db_n    <= 1'b1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
        end else begin
            r_sync1   <= i_raw_n;
            r_sync2   <= r_sync1;
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_hold    <= w_hold;
            r_db_n    <= w_db_n;
            r_press   <= w_press;
            r_release <= w_release;
            r_long    <= w_long;
        end
    end

    // Hold saturates at the long-press threshold so it never wraps
    assign w_hold_inc = (r_hold == c_long) ? r_hold : r_hold + c_one;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_hold    = r_hold;
        w_db_n    = r_db_n;
        w_press   = 1'b0;
        w_release = 1'b0;
        w_long    = r_long;
        case (r_state)
            ST_RELEASED: begin
                w_db_n = 1'b1;
                w_hold = '0;
                w_long = 1'b0;
                if (!r_sync2) begin
                    w_state = ST_PRESS_WAIT;
                    w_cnt   = c_one;
                end
            end
            ST_PRESS_WAIT: begin
                if (r_sync2) begin
                    w_state = ST_RELEASED;
                    w_cnt   = '0;
                end else if (r_cnt == c_deb) begin
                    w_state = ST_PRESSED;
                    w_cnt   = '0;
                    w_db_n  = 1'b0;
                    w_press = 1'b1;
                    w_hold  = '0;
                end else begin
                    w_cnt = r_cnt + c_one;
                end
            end
            ST_PRESSED: begin
                w_db_n = 1'b0;
                w_hold = w_hold_inc;
                w_long = (w_hold_inc == c_long);
                if (r_sync2) begin
                    w_state = ST_RELEASE_WAIT;
                    w_cnt   = c_one;
                end
            end
            ST_RELEASE_WAIT: begin
                // A glitch back to pressed must not disturb hold/long timing
                w_hold = w_hold_inc;
                w_long = (w_hold_inc == c_long);
                if (!r_sync2) begin
                    w_state = ST_PRESSED;
                    w_cnt   = '0;
                end else if (r_cnt == c_deb) begin
                    w_state   = ST_RELEASED;
                    w_cnt     = '0;
                    w_db_n    = 1'b1;
                    w_release = 1'b1;
                    w_long    = 1'b0;
                    w_hold    = '0;
                end else begin
                    w_cnt = r_cnt + c_one;
                end
            end
        endcase
    end

    assign o_db_n    = r_db_n;
    assign o_press   = r_press;
    assign o_release = r_release;
    assign o_long    = r_long;

endmodule : debounce_channel
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Synchronises and debounces the active-low jump and crouch
//               buttons; two independent debounce_channel instances.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = c_default_debounce_cycles,
    parameter int LONG_PRESS_CYCLES = c_default_long_press_cycles,
    parameter int CNT_W             = c_default_cnt_w
) (
    input  wire logic           clk,
    input  wire logic           rst,
    button_conditioner_if.slave btn
);

    debounce_channel #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .CNT_W             (CNT_W)
    ) u_jump (
        .clk       (clk),
        .rst       (rst),
        .i_raw_n   (btn.jump_n),
        .o_db_n    (btn.jump_db_n),
        .o_press   (btn.jump_press),
        .o_release (btn.jump_release),
        .o_long    (btn.jump_long)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES   (DEBOUNCE_CYCLES),
        .LONG_PRESS_CYCLES (LONG_PRESS_CYCLES),
        .CNT_W             (CNT_W)
    ) u_crouch (
        .clk       (clk),
        .rst       (rst),
        .i_raw_n   (btn.crouch_n),
        .o_db_n    (btn.crouch_db_n),
        .o_press   (btn.crouch_press),
        .o_release (btn.crouch_release),
        .o_long    (btn.crouch_long)
    );

endmodule : button_conditioner
`default_nettype wire
